// File: rtl/lcd_cmd_sched_if.sv
// Host command handshake into the LCD command scheduler.
// A push happens on any cycle where host_valid and host_ready are both high.
interface lcd_cmd_sched_if;
    logic [2:0] host_cmd;
    logic       host_valid;
    logic       host_ready;

    modport master (
        output host_cmd,
        output host_valid,
        input  host_ready
    );

    modport slave (
        input  host_cmd,
        input  host_valid,
        output host_ready
    );
endinterface

// File: rtl/lcd_cmd_sched.sv
// Command scheduler for the LCD controller: host FIFO, image streaming for load commands,
// refresh byte counting with frame completion and a watchdog abort.
module lcd_cmd_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    lcd_cmd_sched_if.slave   host,
    output logic [5:0]       img_addr,
    input  logic [7:0]       img_data,
    output logic [2:0]       lcd_cmd,
    output logic             lcd_cmd_valid,
    output logic [7:0]       lcd_datain,
    input  logic             lcd_busy,
    input  logic             lcd_output_valid,
    output logic             frame_done,
    output logic             timeout_err,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);
    localparam logic [4:0] FrameBytes = 5'd16;
    localparam logic [2:0] CmdLoad = 3'd1;

    typedef enum logic [1:0] {StIdle, StIssue, StLoad, StWait} state_e;

    state_e          state_q;
    logic [2:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic [4:0]      byte_cnt_q;
    logic [7:0]      wdog_q;
    logic            push;
    logic            pop;

    // Ready comes from the registered count, so a same-cycle pop never frees a slot early.
    assign host.host_ready = (fifo_cnt_q != FullCnt);
    assign push            = host.host_valid && host.host_ready;
    assign pop             = (state_q == StIssue);
    assign lcd_datain      = (state_q == StLoad) ? img_data : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= host.host_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            lcd_cmd       <= 3'd0;
            lcd_cmd_valid <= 1'b0;
            img_addr      <= 6'd0;
            byte_cnt_q    <= 5'd0;
            wdog_q        <= 8'd0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            frame_cnt     <= 8'd0;
        end else begin
            lcd_cmd_valid <= 1'b0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if ((fifo_cnt_q != '0) && !lcd_busy) begin
                        state_q       <= StIssue;
                        lcd_cmd_valid <= 1'b1;
                        lcd_cmd       <= fifo_mem[rd_ptr_q];
                    end
                end
                StIssue: begin
                    byte_cnt_q <= 5'd0;
                    wdog_q     <= 8'd0;
                    if (lcd_cmd == CmdLoad) begin
                        state_q  <= StLoad;
                        img_addr <= 6'd0;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StLoad: begin
                    byte_cnt_q <= 5'd0;
                    wdog_q     <= 8'd0;
                    if (img_addr == 6'd63) begin
                        state_q <= StWait;
                    end else begin
                        img_addr <= img_addr + 6'd1;
                    end
                end
                StWait: begin
                    // Completion wins over a watchdog expiring in the same cycle.
                    if ((byte_cnt_q >= FrameBytes) && !lcd_busy) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        state_q    <= StIdle;
                    end else if (wdog_q == WdogLast) begin
                        timeout_err <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                        if (lcd_output_valid && (byte_cnt_q < FrameBytes)) begin
                            byte_cnt_q <= byte_cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Scoreboard bench for lcd_cmd_sched: randomized host traffic against a simple controller model.
`timescale 1ns/1ps
module tb_lcd_cmd_sched;

    localparam int unsigned Depth = 4;
    localparam int To = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] img_addr;
    logic [7:0] img_data;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic       lcd_busy;
    logic       lcd_output_valid = 1'b0;
    logic       frame_done;
    logic       timeout_err;
    logic [7:0] frame_cnt;
    logic       ctrl_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic [7:0] rom [64];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issued = 0;
    int force_nout = 0;
    bit in_reset = 1'b0;
    bit load_win = 1'b0;
    bit ctrl_active = 1'b0;
    bit prev_valid = 1'b0;
    logic [2:0] last_cmd = 3'd0;
    logic [7:0] exp_frames = 8'd0;

    logic [2:0] exp_cmd [$];
    bit         exp_to [$];
    int         exp_cyc [$];

    lcd_cmd_sched_if host_if ();

    assign lcd_busy = ctrl_busy | hold_busy;
    assign img_data = rom[img_addr];

    lcd_cmd_sched #(
        .FIFO_DEPTH(Depth),
        .TIMEOUT   (To)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .host            (host_if),
        .img_addr        (img_addr),
        .img_data        (img_data),
        .lcd_cmd         (lcd_cmd),
        .lcd_cmd_valid   (lcd_cmd_valid),
        .lcd_datain      (lcd_datain),
        .lcd_busy        (lcd_busy),
        .lcd_output_valid(lcd_output_valid),
        .frame_done      (frame_done),
        .timeout_err     (timeout_err),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Issued commands must come out in push order, one-cycle strobes, cmd held otherwise.
    initial begin : cmd_mon
        forever begin
            @(negedge clk);
            if (in_reset) begin
                exp_cmd.delete();
                last_cmd   = 3'd0;
                prev_valid = 1'b0;
            end else if (lcd_cmd_valid) begin
                issued++;
                chk("valid_single", 32'(prev_valid), 0);
                if (exp_cmd.size() == 0) begin
                    chk("issue_when_empty", 32'(lcd_cmd_valid), 0);
                end else begin
                    last_cmd = exp_cmd.pop_front();
                    chk("cmd_order", 32'(lcd_cmd), 32'(last_cmd));
                end
                prev_valid = 1'b1;
            end else begin
                chk("cmd_hold", 32'(lcd_cmd), 32'(last_cmd));
                prev_valid = 1'b0;
            end
            if (!load_win) chk("datain_zero", 32'(lcd_datain), 0);
        end
    end

    // Controller model: stays busy, returns n output bytes, then drops busy.
    initial begin : ctrl
        logic [2:0] c;
        int n;
        int got;
        forever begin
            @(negedge clk);
            if (!in_reset && lcd_cmd_valid) begin
                c = lcd_cmd;
                ctrl_active = 1'b1;
                ctrl_busy   = 1'b1;
                if (force_nout != 0) begin
                    n = force_nout;
                end else begin
                    case ($urandom_range(0, 7))
                        0: n = int'($urandom_range(0, 15));
                        1: n = 17;
                        2: n = 20;
                        default: n = 16;
                    endcase
                end
                exp_to.push_back(n < 16);
                exp_cyc.push_back(cyc + To + 1 + ((c == 3'd1) ? 64 : 0));
                if (c == 3'd1) begin
                    load_win = 1'b1;
                    for (int k = 0; k < 64 && !in_reset; k++) begin
                        @(negedge clk);
                        if (!in_reset) begin
                            chk("img_addr", 32'(img_addr), k);
                            chk("load_byte", 32'(lcd_datain), 32'(rom[6'(k)]));
                        end
                    end
                end
                @(negedge clk);
                load_win = 1'b0;
                got = 0;
                while (got < n && !in_reset) begin
                    if ($urandom_range(0, 1) != 0) begin
                        lcd_output_valid = 1'b1;
                        got++;
                    end else begin
                        lcd_output_valid = 1'b0;
                    end
                    @(negedge clk);
                end
                lcd_output_valid = 1'b0;
                ctrl_busy        = 1'b0;
                ctrl_active      = 1'b0;
            end
        end
    end

    initial begin : out_mon
        bit to;
        int ec;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                exp_to.delete();
                exp_cyc.delete();
                exp_frames = 8'd0;
            end else if (frame_done || timeout_err) begin
                chk("done_excl", 32'(frame_done & timeout_err), 0);
                if (exp_to.size() == 0) begin
                    chk("outcome_unexpected", 32'(frame_done | timeout_err), 0);
                end else begin
                    to = exp_to.pop_front();
                    ec = exp_cyc.pop_front();
                    chk("outcome_kind", 32'(timeout_err), 32'(to));
                    if (to) chk("timeout_cycle", cyc, ec);
                    else exp_frames = exp_frames + 8'd1;
                    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
                end
            end
        end
    end

    task automatic drive_cycle(input bit v, input logic [2:0] c, output bit acc);
        @(negedge clk);
        #1;
        host_if.host_valid = v;
        host_if.host_cmd   = c;
        acc = v && host_if.host_ready;
        if (acc) exp_cmd.push_back(c);
    endtask

    task automatic push_one(input logic [2:0] c);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 3000) begin
            drive_cycle(1'b1, c, acc);
            n++;
        end
        chk("push_accepted", 32'(acc), 1);
        @(negedge clk);
        #1;
        host_if.host_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_to.size() != 0 || ctrl_active) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_bound", 32'(n < 5000), 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_host_ready"}, 32'(host_if.host_ready), 1);
        chk({tag, "_lcd_cmd"}, 32'(lcd_cmd), 0);
        chk({tag, "_cmd_valid"}, 32'(lcd_cmd_valid), 0);
        chk({tag, "_datain"}, 32'(lcd_datain), 0);
        chk({tag, "_img_addr"}, 32'(img_addr), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    initial begin : main
        bit acc;
        int snap;
        int n;
        for (int i = 0; i < 64; i++) rom[i] = 8'(i + 16);
        host_if.host_valid = 1'b0;
        host_if.host_cmd   = 3'd0;
        in_reset = 1'b1;
        #1;
        reset_checks("rst");
        repeat (2) @(negedge clk);
        #1;
        reset    = 1'b1;
        in_reset = 1'b0;

        push_one(3'd3);
        drain();
        push_one(3'd1);
        drain();

        force_nout = 10;
        push_one(3'd0);
        drain();
        force_nout = 0;
        push_one(3'd2);
        drain();

        // Fill the FIFO while the controller is held busy.
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 3'($urandom_range(0, 7)), acc);
            chk("fill_host_ready", 32'(host_if.host_ready), 32'(i < int'(Depth)));
        end
        @(negedge clk);
        #1;
        host_if.host_valid = 1'b0;
        snap = issued;
        repeat (20) @(negedge clk);
        #1;
        chk("busy_hold_no_issue", issued, snap);
        chk("full_not_ready", 32'(host_if.host_ready), 0);
        hold_busy = 1'b0;
        n = 0;
        while (!host_if.host_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready_after_first_pop", issued, snap + 1);
        drain();

        for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_one(3'($urandom_range(0, 7)));
        end
        drain();

        // Reset in the middle of a load with more commands queued behind it.
        push_one(3'd1);
        push_one(3'd0);
        push_one(3'd5);
        n = 0;
        while (img_addr != 6'd30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_addr30", 32'(img_addr), 30);
        #2;
        in_reset = 1'b1;
        reset    = 1'b0;
        #1;
        reset_checks("midload");
        repeat (3) @(negedge clk);
        #1;
        reset    = 1'b1;
        in_reset = 1'b0;
        snap = issued;
        repeat (10) @(negedge clk);
        #1;
        chk("fifo_flushed", issued, snap);
        chk("post_reset_ready", 32'(host_if.host_ready), 1);
        push_one(3'd4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : global_guard
        #900000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench did not complete");
    end

endmodule
